lpddr_apb_arb: RTL and testbench

LPDDR_APB_ARB -- requirements
Module: lpddr_apb_arb

---
 rtl/lpddr_pkg.sv | 15 +
 rtl/lpddr_rr_arb.sv | 43 ++++
 rtl/lpddr_apb_arb.sv | 175 +++++++++++++++++
 tb/tb_lpddr_apb_arb.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpddr_pkg.sv
// Shared types and APB widths for the LPDDR APB arbiter.
package lpddr_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 32;

  // Transfer phases of the APB master.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/lpddr_rr_arb.sv
// Combinational round-robin picker: search starts one past last_grant and wraps.
module lpddr_rr_arb #(
  parameter int NREQ = 2,
  parameter int IDXW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] last_grant,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IDXW-1:0] grant_idx,
  output logic            any
);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREQ - 1);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

  logic [IDXW-1:0] cand_s;

  // Walk the candidates in rotating priority order and keep the first one requesting.
  always_comb begin
    cand_s    = last_grant;
    any       = 1'b0;
    grant_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (cand_s == IDX_LAST) begin
        cand_s = '0;
      end else begin
        cand_s = cand_s + 1'b1;
      end
      if (!any && req[cand_s]) begin
        any       = 1'b1;
        grant_idx = cand_s;
      end else begin
        grant_idx = grant_idx;
      end
    end
    if (any) begin
      grant_onehot = ONE_HOT0 << grant_idx;
    end else begin
      grant_onehot = '0;
    end
  end

endmodule

// File: rtl/lpddr_apb_arb.sv
// Arbitrates NREQ requesters onto a single APB master port with a wait-state timeout.
module lpddr_apb_arb
  import lpddr_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0]            req_write,
  input  logic [NREQ*APB_ADDR_W-1:0] req_addr,
  input  logic [NREQ*APB_DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]            req_ack,
  output logic                       req_err,
  output logic [APB_DATA_W-1:0]      req_rdata,
  output logic                       busy,
  output logic [APB_ADDR_W-1:0]      paddr,
  output logic [APB_DATA_W-1:0]      pwdata,
  output logic                       pwrite,
  output logic                       psel,
  output logic                       penable,
  input  logic                       pready,
  input  logic [APB_DATA_W-1:0]      prdata
);

  localparam int IDXW  = $clog2(NREQ);
  localparam int WAITW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(TIMEOUT_CYC - 1);

  state_e                  state_q, state_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [APB_ADDR_W-1:0]   paddr_q, paddr_d;
  logic [APB_DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NREQ-1:0]         ack_q, ack_d;
  logic                    err_q, err_d;
  logic [APB_DATA_W-1:0]   rdata_q, rdata_d;
  logic                    busy_q, busy_d;
  logic [WAITW-1:0]        wait_q, wait_d;
  logic [IDXW-1:0]         last_grant_q, last_grant_d;
  logic [NREQ-1:0]         grant_oh_q, grant_oh_d;

  logic [NREQ-1:0]            rr_onehot_s;
  logic [IDXW-1:0]            rr_idx_s;
  logic                       rr_any_s;
  logic [NREQ*APB_ADDR_W-1:0] addr_shift_s;
  logic [NREQ*APB_DATA_W-1:0] wdata_shift_s;

  lpddr_rr_arb #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_rr_arb (
    .req          (req_valid),
    .last_grant   (last_grant_q),
    .grant_onehot (rr_onehot_s),
    .grant_idx    (rr_idx_s),
    .any          (rr_any_s)
  );

  // Bring the winner's address and write data down to the low lanes.
  always_comb begin
    addr_shift_s  = req_addr >> (APB_ADDR_W * rr_idx_s);
    wdata_shift_s = req_wdata >> (APB_DATA_W * rr_idx_s);
  end

  // Next-state and next-output logic; completion outputs default to zero every cycle.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    ack_d        = '0;
    err_d        = 1'b0;
    rdata_d      = '0;
    wait_d       = wait_q;
    last_grant_d = last_grant_q;
    grant_oh_d   = grant_oh_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_any_s) begin
          state_d      = ST_SETUP;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = req_write[rr_idx_s];
          paddr_d      = addr_shift_s[APB_ADDR_W-1:0];
          pwdata_d     = wdata_shift_s[APB_DATA_W-1:0];
          last_grant_d = rr_idx_s;
          grant_oh_d   = rr_onehot_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d   = ST_DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = grant_oh_q;
          rdata_d   = pwrite_q ? '0 : prdata;
        end else if (wait_q == WAIT_LAST) begin
          // Slave never answered: give up and report the failure to the requester.
          state_d   = ST_DONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = grant_oh_q;
          err_d     = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= ST_IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      busy_q       <= 1'b0;
      wait_q       <= '0;
      last_grant_q <= IDXW'(NREQ - 1);
      grant_oh_q   <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      wait_q       <= wait_d;
      last_grant_q <= last_grant_d;
      grant_oh_q   <= grant_oh_d;
    end
  end

  assign req_ack   = ack_q;
  assign req_err   = err_q;
  assign req_rdata = rdata_q;
  assign busy      = busy_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign pwrite    = pwrite_q;
  assign psel      = psel_q;
  assign penable   = penable_q;

endmodule

// File: tb/tb_lpddr_apb_arb.sv
// Scoreboard bench for lpddr_apb_arb: requester driver, APB slave, transaction-level model.
module tb_lpddr_apb_arb;

  localparam int NREQ = 3;
  localparam int TO   = 16;

  logic                 pclk = 1'b0;
  logic                 presetn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [NREQ*16-1:0]   req_addr;
  logic [NREQ*32-1:0]   req_wdata;
  logic [NREQ-1:0]      req_ack;
  logic                 req_err;
  logic [31:0]          req_rdata;
  logic                 busy;
  logic [15:0]          paddr;
  logic [31:0]          pwdata;
  logic                 pwrite;
  logic                 psel;
  logic                 penable;
  logic                 pready;
  logic [31:0]          prdata;

  lpddr_apb_arb #(.NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
    .pclk(pclk), .presetn(presetn), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .req_err(req_err),
    .req_rdata(req_rdata), .busy(busy), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
    .psel(psel), .penable(penable), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int          idx;
    logic        write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        err;
    int          setup_cyc;
    int          ack_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        e, front;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          fix_w = 0;
  int          cur_w = 0;
  bit          rand_on = 1'b0;
  int          rem[NREQ];
  logic [NREQ-1:0] pending;
  int          cur_owner = -1;
  int          ack_idx_log[$];
  int          ack_cyc_log[$];
  logic        err_log[$];
  logic [31:0] rdata_log[$];
  bit [31:0]   smem[16];
  bit [31:0]   rmem[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Round-robin reference: first requester at or after last+1, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // APB slave: wait states chosen at SETUP, memory indexed by paddr[3:0].
  initial begin
    int k;
    k = 0;
    pready = 1'b0;
    prdata = 32'd0;
    forever begin
      @(posedge pclk);
      #1;
      if (!presetn) begin
        k = 0;
        pready = 1'b0;
      end else if (psel && !penable) begin
        if (fix_w >= 0) cur_w = fix_w;
        else begin
          int r;
          r = $urandom_range(0, 19);
          if (r < 12) cur_w = 0;
          else if (r < 18) cur_w = $urandom_range(1, 4);
          else if (r == 18) cur_w = TO - 1;
          else cur_w = TO;
        end
        k = 0;
        pready = 1'b0;
        prdata = $urandom;
      end else if (psel && penable) begin
        k++;
        if (k > cur_w) begin
          pready = 1'b1;
          if (pwrite) begin
            smem[paddr[3:0]] = pwdata;
            prdata = $urandom;
          end else begin
            prdata = smem[paddr[3:0]];
          end
        end else begin
          pready = 1'b0;
          prdata = $urandom;
        end
      end else begin
        pready = 1'b0;
        prdata = $urandom;
      end
    end
  end

  // Monitor: predicts grants, checks APB phases, pops expectations on every ack.
  initial begin
    bit              outstanding, ostart, expect_setup, setup_now;
    logic [NREQ-1:0] prev_valid;
    int              model_last, w, aidx;
    logic [31:0]     exp_rdata;
    outstanding = 1'b0;
    expect_setup = 1'b0;
    prev_valid = '0;
    model_last = NREQ - 1;
    forever begin
      @(negedge pclk);
      cyc++;
      if (!presetn) begin
        sb_q.delete();
        outstanding = 1'b0;
        expect_setup = 1'b0;
        model_last = NREQ - 1;
        cur_owner = -1;
        prev_valid = req_valid;
      end else begin
        ostart = outstanding;
        setup_now = psel && !penable && !outstanding;
        if (!outstanding) chk("grant_timing", {63'd0, setup_now}, {63'd0, expect_setup});
        if (setup_now) begin
          w = rr_pick(prev_valid, model_last);
          if (w < 0) w = 0;
          e.idx = w;
          e.write = req_write[w];
          e.addr = req_addr[w*16 +: 16];
          e.wdata = req_wdata[w*32 +: 32];
          e.err = (cur_w >= TO);
          e.setup_cyc = cyc;
          e.ack_cyc = cyc + (e.err ? 1 + TO : 2 + cur_w);
          sb_q.push_back(e);
          outstanding = 1'b1;
          model_last = w;
          cur_owner = w;
        end
        if (outstanding) begin
          front = sb_q[0];
          chk("psel", {63'd0, psel}, {63'd0, cyc < front.ack_cyc});
          chk("penable", {63'd0, penable}, {63'd0, (cyc > front.setup_cyc) && (cyc < front.ack_cyc)});
          chk("busy", {63'd0, busy}, 64'd1);
          if (cyc < front.ack_cyc) begin
            chk("paddr", {48'd0, paddr}, {48'd0, front.addr});
            chk("pwdata", {32'd0, pwdata}, {32'd0, front.wdata});
            chk("pwrite", {63'd0, pwrite}, {63'd0, front.write});
          end
        end else begin
          chk("psel_idle", {63'd0, psel}, 64'd0);
          chk("busy_idle", {63'd0, busy}, 64'd0);
        end
        if (req_ack != '0) begin
          aidx = 0;
          for (int i = 0; i < NREQ; i++) if (req_ack[i]) aidx = i;
          ack_idx_log.push_back(aidx);
          ack_cyc_log.push_back(cyc);
          err_log.push_back(req_err);
          rdata_log.push_back(req_rdata);
          if (!outstanding) begin
            chk("ack_unexpected", {{(64-NREQ){1'b0}}, req_ack}, 64'd0);
          end else begin
            front = sb_q.pop_front();
            exp_rdata = (front.err || front.write) ? 32'd0 : rmem[front.addr[3:0]];
            if (!front.err && front.write) rmem[front.addr[3:0]] = front.wdata;
            chk("ack_onehot", {{(64-NREQ){1'b0}}, req_ack}, 64'd1 << front.idx);
            chk("ack_err", {63'd0, req_err}, {63'd0, front.err});
            chk("ack_rdata", {32'd0, req_rdata}, {32'd0, exp_rdata});
            chk("ack_cycle", 64'(cyc), 64'(front.ack_cyc));
            outstanding = 1'b0;
          end
        end else begin
          chk("err_quiet", {63'd0, req_err}, 64'd0);
          chk("rdata_quiet", {32'd0, req_rdata}, 64'd0);
          if (outstanding && cyc >= sb_q[0].ack_cyc) begin
            front = sb_q.pop_front();
            chk("ack_missing", {{(64-NREQ){1'b0}}, req_ack}, 64'd1 << front.idx);
            outstanding = 1'b0;
          end
        end
        expect_setup = !ostart && !setup_now && (req_valid != '0);
        prev_valid = req_valid;
      end
    end
  end

  task automatic issue(input int i, input logic wr, input logic [15:0] a, input logic [31:0] d);
    req_write[i] = wr;
    req_addr[i*16 +: 16] = a;
    req_wdata[i*32 +: 32] = d;
    req_valid[i] = 1'b1;
    pending[i] = 1'b1;
  endtask

  task automatic new_rand(input int i);
    issue(i, 1'($urandom_range(0, 1)), 16'($urandom), $urandom);
  endtask

  // One driver cycle: retire acked requests, optionally reload, start or withdraw randomly.
  task automatic step();
    @(posedge pclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (presetn && req_ack[i]) begin
        pending[i] = 1'b0;
        req_valid[i] = 1'b0;
        if (rem[i] > 0) begin
          rem[i]--;
          new_rand(i);
        end
      end else if (rand_on && !pending[i]) begin
        if ($urandom_range(0, 3) == 0) new_rand(i);
      end else if (rand_on && req_valid[i] && psel && penable && cur_owner == i) begin
        if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run_idle(input int maxc);
    int n;
    n = 0;
    step();
    while ((pending != '0 || busy) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_pending", {{(64-NREQ){1'b0}}, pending}, 64'd0);
    repeat (2) step();
  endtask

  initial begin
    int base, n;
    presetn = 1'b0;
    req_valid = '0;
    req_write = '0;
    req_addr = '0;
    req_wdata = '0;
    pending = '0;
    for (int i = 0; i < NREQ; i++) rem[i] = 0;
    @(posedge pclk);
    #1;
    chk("rst_psel", {63'd0, psel}, 64'd0);
    chk("rst_penable", {63'd0, penable}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ack", {{(64-NREQ){1'b0}}, req_ack}, 64'd0);
    chk("rst_err", {63'd0, req_err}, 64'd0);
    chk("rst_rdata", {32'd0, req_rdata}, 64'd0);
    chk("rst_paddr", {48'd0, paddr}, 64'd0);
    chk("rst_pwdata", {32'd0, pwdata}, 64'd0);
    chk("rst_pwrite", {63'd0, pwrite}, 64'd0);
    @(posedge pclk);
    #1;
    presetn = 1'b1;

    // Single write from requester 0.
    fix_w = 0;
    base = ack_idx_log.size();
    issue(0, 1'b1, 16'h0003, 32'hDEADBEEF);
    run_idle(100);
    chk("write_ack_count", 64'(ack_idx_log.size() - base), 64'd1);
    if (ack_idx_log.size() > base) begin
      chk("write_ack_idx", 64'(ack_idx_log[base]), 64'd0);
      chk("write_err", {63'd0, err_log[base]}, 64'd0);
    end

    // Read-back by requester 1.
    base = ack_idx_log.size();
    issue(1, 1'b0, 16'h0003, 32'h0);
    run_idle(100);
    chk("read_ack_count", 64'(ack_idx_log.size() - base), 64'd1);
    if (ack_idx_log.size() > base) begin
      chk("read_ack_idx", 64'(ack_idx_log[base]), 64'd1);
      chk("read_rdata", {32'd0, rdata_log[base]}, 64'hDEADBEEF);
    end

    // Contention: both held for four transfers.
    base = ack_idx_log.size();
    rem[0] = 1;
    rem[1] = 1;
    new_rand(0);
    new_rand(1);
    run_idle(100);
    chk("contention_count", 64'(ack_idx_log.size() - base), 64'd4);
    if (ack_idx_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk("contention_order", 64'(ack_idx_log[base+k]), 64'(k % 2));
      for (int k = 0; k < 3; k++)
        chk("contention_spacing", 64'(ack_cyc_log[base+k+1] - ack_cyc_log[base+k]), 64'd4);
    end

    // Three wait states on requester 2.
    fix_w = 3;
    issue(2, 1'b1, 16'hA5C3, 32'h1234_5678);
    run_idle(100);

    // Timeout with a stuck slave.
    fix_w = TO + 4;
    base = ack_idx_log.size();
    issue(1, 1'b0, 16'h0003, 32'h0);
    run_idle(200);
    chk("timeout_count", 64'(ack_idx_log.size() - base), 64'd1);
    if (ack_idx_log.size() > base) begin
      chk("timeout_err", {63'd0, err_log[base]}, 64'd1);
      chk("timeout_rdata", {32'd0, rdata_log[base]}, 64'd0);
    end

    // Reset in the middle of an ACCESS granted to requester 0.
    fix_w = 10;
    issue(0, 1'b1, 16'h0007, 32'hCAFE_F00D);
    n = 0;
    step();
    while (!(psel && penable) && n < 20) begin
      step();
      n++;
    end
    chk("reached_access", {63'd0, psel && penable}, 64'd1);
    #2;
    presetn = 1'b0;
    #1;
    chk("rst_mid_psel", {63'd0, psel}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_ack", {{(64-NREQ){1'b0}}, req_ack}, 64'd0);
    issue(1, 1'b1, 16'h0009, 32'h0BAD_CAFE);
    fix_w = 0;
    base = ack_idx_log.size();
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    run_idle(100);
    chk("post_rst_count", 64'(ack_idx_log.size() - base), 64'd2);
    if (ack_idx_log.size() > base) chk("post_rst_first", 64'(ack_idx_log[base]), 64'd0);

    // Randomized traffic with random wait states, timeouts and withdrawn requests.
    fix_w = -1;
    rand_on = 1'b1;
    repeat (1500) step();
    rand_on = 1'b0;
    run_idle(600);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
